// File: rtl/msg_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous-read message ROM among several decrypt cores.
// Each grant issues one ROM read and returns the byte with a single-cycle ack.
module msg_rom_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ADDR_W  = 5,
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*ADDR_W-1:0] addr,
   output logic [NUM_REQ-1:0]        ack,
   output logic [DATA_W-1:0]         rdata,
   output logic [ADDR_W-1:0]         rom_address,
   input  logic [DATA_W-1:0]         rom_q,
   output logic                      busy,
   output logic [ID_W-1:0]           grant_id
);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StRespond} state_e;

   state_e              state_q, state_d;
   logic [ID_W-1:0]     last_grant_q, last_grant_d;
   logic [ID_W-1:0]     grant_id_q, grant_id_d;
   logic [ADDR_W-1:0]   rom_address_q, rom_address_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic [NUM_REQ-1:0]  ack_q, ack_d;
   logic                busy_q, busy_d;

   logic                found;
   logic [ID_W-1:0]     winner;
   int unsigned         idx;

   // Search starts one past the last grant so every requester is reached within NUM_REQ tries.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = 0;
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         idx = (32'(last_grant_q) + i) % NUM_REQ;
         if (!found && req[idx]) begin
            found  = 1'b1;
            winner = idx[ID_W-1:0];
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      last_grant_d  = last_grant_q;
      grant_id_d    = grant_id_q;
      rom_address_d = rom_address_q;
      rdata_d       = rdata_q;
      ack_d         = '0;
      unique case (state_q)
         StIdle: begin
            if (found) begin
               state_d       = StIssue;
               grant_id_d    = winner;
               last_grant_d  = winner;
               rom_address_d = addr[32'(winner)*ADDR_W +: ADDR_W];
            end
         end
         StIssue: state_d = StWait;
         StWait: begin
            // A dropped request means the core aborted; the read result is discarded.
            if (req[grant_id_q]) begin
               rdata_d            = rom_q;
               ack_d[grant_id_q]  = 1'b1;
               state_d            = StRespond;
            end else begin
               state_d = StIdle;
            end
         end
         StRespond: state_d = StIdle;
         default:   state_d = StIdle;
      endcase
      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q       <= StIdle;
         last_grant_q  <= ID_W'(NUM_REQ - 1);
         grant_id_q    <= '0;
         rom_address_q <= '0;
         rdata_q       <= '0;
         ack_q         <= '0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_grant_q  <= last_grant_d;
         grant_id_q    <= grant_id_d;
         rom_address_q <= rom_address_d;
         rdata_q       <= rdata_d;
         ack_q         <= ack_d;
         busy_q        <= busy_d;
      end
   end

   assign ack         = ack_q;
   assign rdata       = rdata_q;
   assign rom_address = rom_address_q;
   assign busy        = busy_q;
   assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_msg_rom_arbiter.sv
// Self-checking bench for msg_rom_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level round-robin model.
module tb_msg_rom_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [3:0]  req;
   logic [19:0] addr;
   logic [3:0]  ack;
   logic [7:0]  rdata;
   logic [4:0]  rom_address;
   logic [7:0]  rom_q;
   logic        busy;
   logic [1:0]  grant_id;

   logic [7:0]  rom [32];

   int checks = 0;
   int passes = 0;
   int m_last;
   logic [7:0] m_rdata;

   always #5 clk = ~clk;

   always @(posedge clk) rom_q <= rom[rom_address];

   msg_rom_arbiter #(.NUM_REQ(4), .ADDR_W(5), .DATA_W(8)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .req         (req),
      .addr        (addr),
      .ack         (ack),
      .rdata       (rdata),
      .rom_address (rom_address),
      .rom_q       (rom_q),
      .busy        (busy),
      .grant_id    (grant_id)
   );

   // Reference: first requester found scanning upward from one past the last grant.
   function automatic int rr_pick(input int last, input logic [3:0] r);
      for (int i = 1; i <= 4; i++) begin
         if (r[(last + i) % 4]) return (last + i) % 4;
      end
      return -1;
   endfunction

   function automatic logic [4:0] addr_of(input int k);
      return addr[k*5 +: 5];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      req     = 4'b1111;
      addr    = 20'($urandom);
      step();
      step();
      checks++; if (ack !== 4'b0) $display("FAIL reset_ack got %b want 0000", ack); else passes++;
      checks++; if (rdata !== 8'h00) $display("FAIL reset_rdata got %h want 00", rdata); else passes++;
      checks++; if (rom_address !== 5'd0) $display("FAIL reset_rom_address got %0d want 0", rom_address); else passes++;
      checks++; if (grant_id !== 2'd0) $display("FAIL reset_grant_id got %0d want 0", grant_id); else passes++;
      checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passes++;
      req     = 4'b0;
      reset_n = 1'b1;
      m_last  = 3;
      m_rdata = 8'h00;
   endtask

   task automatic test_single();
      addr       = 20'($urandom);
      addr[4:0]  = 5'd7;
      rom[7]     = 8'hA5;
      req        = 4'b0001;
      step();
      checks++; if (grant_id !== 2'd0) $display("FAIL single_grant got %0d want 0", grant_id); else passes++;
      checks++; if (rom_address !== 5'd7) $display("FAIL single_rom_address got %0d want 7", rom_address); else passes++;
      checks++; if (busy !== 1'b1) $display("FAIL single_busy got %b want 1", busy); else passes++;
      step();
      checks++; if (ack !== 4'b0) $display("FAIL single_early_ack got %b want 0000", ack); else passes++;
      step();
      checks++; if (ack !== 4'b0001) $display("FAIL single_ack got %b want 0001", ack); else passes++;
      checks++; if (rdata !== 8'hA5) $display("FAIL single_rdata got %h want a5", rdata); else passes++;
      req = 4'b0;
      step();
      checks++; if (ack !== 4'b0) $display("FAIL single_ack_drop got %b want 0000", ack); else passes++;
      checks++; if (busy !== 1'b0) $display("FAIL single_idle got %b want 0", busy); else passes++;
      m_last  = 0;
      m_rdata = 8'hA5;
   endtask

   task automatic test_all_req();
      int w;
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      m_last  = 3;
      addr    = 20'($urandom);
      req     = 4'b1111;
      for (int g = 0; g < 8; g++) begin
         w = rr_pick(m_last, req);
         step();
         checks++; if (grant_id !== 2'(w)) $display("FAIL all_grant[%0d] got %0d want %0d", g, grant_id, w); else passes++;
         checks++; if (rom_address !== addr_of(w)) $display("FAIL all_rom_address[%0d] got %0d want %0d", g, rom_address, addr_of(w)); else passes++;
         step();
         step();
         checks++; if (ack !== (4'b0001 << w)) $display("FAIL all_ack[%0d] got %b want core %0d", g, ack, w); else passes++;
         checks++; if (rdata !== rom[addr_of(w)]) $display("FAIL all_rdata[%0d] got %h want %h", g, rdata, rom[addr_of(w)]); else passes++;
         m_last  = w;
         m_rdata = rom[addr_of(w)];
         step();
         checks++; if (busy !== 1'b0 || ack !== 4'b0) $display("FAIL all_idle_gap[%0d] got busy=%b ack=%b want 0 0000", g, busy, ack); else passes++;
      end
      req = 4'b0;
   endtask

   task automatic test_wrap();
      int w;
      req = 4'b1001;
      for (int g = 0; g < 2; g++) begin
         w = rr_pick(m_last, req);
         step();
         checks++; if (grant_id !== 2'(w)) $display("FAIL wrap_grant[%0d] got %0d want %0d", g, grant_id, w); else passes++;
         step();
         step();
         checks++; if (ack !== (4'b0001 << w)) $display("FAIL wrap_ack[%0d] got %b want core %0d", g, ack, w); else passes++;
         m_last  = w;
         m_rdata = rom[addr_of(w)];
         step();
      end
      req = 4'b0;
   endtask

   task automatic test_abort();
      int w;
      addr = 20'($urandom);
      req  = 4'b1100;
      w    = rr_pick(m_last, req);
      step();
      checks++; if (grant_id !== 2'(w)) $display("FAIL abort_grant got %0d want %0d", grant_id, w); else passes++;
      req[w] = 1'b0;
      m_last = w;
      step();
      checks++; if (ack !== 4'b0) $display("FAIL abort_ack_wait got %b want 0000", ack); else passes++;
      step();
      checks++; if (ack !== 4'b0) $display("FAIL abort_ack got %b want 0000", ack); else passes++;
      checks++; if (busy !== 1'b0) $display("FAIL abort_idle got %b want 0", busy); else passes++;
      checks++; if (rdata !== m_rdata) $display("FAIL abort_rdata got %h want %h", rdata, m_rdata); else passes++;
      w = rr_pick(m_last, req);
      step();
      checks++; if (grant_id !== 2'(w)) $display("FAIL abort_next_grant got %0d want %0d", grant_id, w); else passes++;
      step();
      step();
      checks++; if (ack !== (4'b0001 << w)) $display("FAIL abort_next_ack got %b want core %0d", ack, w); else passes++;
      m_last  = w;
      m_rdata = rom[addr_of(w)];
      req     = 4'b0;
      step();
   endtask

   task automatic test_reset_mid();
      int w;
      addr = 20'($urandom);
      req  = 4'b0010;
      step();
      step();
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      checks++; if (ack !== 4'b0 || rdata !== 8'h00) $display("FAIL midreset_ack_rdata got %b %h want 0000 00", ack, rdata); else passes++;
      checks++; if (rom_address !== 5'd0 || grant_id !== 2'd0 || busy !== 1'b0) $display("FAIL midreset_state got addr=%0d id=%0d busy=%b want 0 0 0", rom_address, grant_id, busy); else passes++;
      m_last  = 3;
      m_rdata = 8'h00;
      req     = 4'b0110;
      w       = rr_pick(m_last, req);
      step();
      checks++; if (grant_id !== 2'(w)) $display("FAIL midreset_grant got %0d want %0d", grant_id, w); else passes++;
      step();
      step();
      checks++; if (ack !== (4'b0001 << w) || rdata !== rom[addr_of(w)]) $display("FAIL midreset_ack got %b %h want core %0d %h", ack, rdata, w, rom[addr_of(w)]); else passes++;
      m_last  = w;
      m_rdata = rom[addr_of(w)];
      req     = 4'b0;
      step();
   endtask

   task automatic test_addr_stable();
      rom[3]     = 8'h3C;
      rom[9]     = 8'hC3;
      addr[9:5]  = 5'd3;
      req        = 4'b0010;
      step();
      checks++; if (grant_id !== 2'd1 || rom_address !== 5'd3) $display("FAIL stable_grant got id=%0d addr=%0d want 1 3", grant_id, rom_address); else passes++;
      addr[9:5] = 5'd9;
      step();
      checks++; if (rom_address !== 5'd3) $display("FAIL stable_rom_address got %0d want 3", rom_address); else passes++;
      step();
      checks++; if (ack !== 4'b0010 || rdata !== 8'h3C) $display("FAIL stable_rdata got %b %h want 0010 3c", ack, rdata); else passes++;
      m_last  = 1;
      m_rdata = 8'h3C;
      req     = 4'b0;
      step();
   endtask

   task automatic test_random();
      int w;
      bit abort;
      for (int r = 0; r < 40; r++) begin
         for (int k = 0; k < 4; k++) begin
            if (!req[k]) begin
               addr[k*5 +: 5] = 5'($urandom);
               req[k]         = 1'($urandom);
            end
         end
         if (req == 4'b0) req[$urandom_range(0, 3)] = 1'b1;
         w     = rr_pick(m_last, req);
         abort = ($urandom_range(0, 4) == 0);
         step();
         checks++; if (grant_id !== 2'(w) || rom_address !== addr_of(w) || busy !== 1'b1) $display("FAIL rand_grant[%0d] got id=%0d addr=%0d busy=%b want %0d %0d 1", r, grant_id, rom_address, busy, w, addr_of(w)); else passes++;
         m_last = w;
         if (abort) req[w] = 1'b0;
         step();
         checks++; if (ack !== 4'b0) $display("FAIL rand_early_ack[%0d] got %b want 0000", r, ack); else passes++;
         step();
         if (abort) begin
            checks++; if (ack !== 4'b0 || busy !== 1'b0 || rdata !== m_rdata) $display("FAIL rand_abort[%0d] got ack=%b busy=%b rdata=%h want 0000 0 %h", r, ack, busy, rdata, m_rdata); else passes++;
         end else begin
            m_rdata = rom[addr_of(w)];
            checks++; if (ack !== (4'b0001 << w) || rdata !== m_rdata) $display("FAIL rand_ack[%0d] got ack=%b rdata=%h want core %0d %h", r, ack, rdata, w, m_rdata); else passes++;
            req[w] = 1'($urandom);
            if (req[w]) addr[w*5 +: 5] = 5'($urandom);
            step();
            checks++; if (ack !== 4'b0 || busy !== 1'b0) $display("FAIL rand_idle[%0d] got ack=%b busy=%b want 0000 0", r, ack, busy); else passes++;
         end
      end
      req = 4'b0;
      step();
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rom[i] = 8'($urandom);
      reset_n = 1'b0;
      req     = 4'b0;
      addr    = '0;
      test_reset();
      test_single();
      test_all_req();
      test_wrap();
      test_abort();
      test_reset_mid();
      test_addr_stable();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
